// File: rtl/dlfloat16_round_pack.sv
// Round-to-nearest-even and pack stage for the DLfloat16 square-root result.
// One-cycle registered output with a skid register so in_ready never depends on out_ready.
module dlfloat16_round_pack #(
  parameter bit          SATURATE = 1'b1,
  parameter logic [15:0] NAN_CODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_data,
  input  logic [4:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  out_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  // Flag bit order: {invalid, inexact, overflow, underflow, div_by_zero}
  localparam logic [4:0] FL_INV = 5'b10000;
  localparam logic [4:0] FL_NX  = 5'b01000;
  localparam logic [4:0] FL_OF  = 5'b00100;
  localparam logic [4:0] FL_UF  = 5'b00010;

  logic        sign;
  logic [5:0]  exp_in;
  logic [12:0] mant;
  logic        lsb, guard, sticky, round_up, overflow;
  logic [9:0]  frac_sum;
  logic [8:0]  frac_r;
  logic [6:0]  exp_r;
  logic [15:0] res_data;
  logic [4:0]  res_flags;

  assign sign   = in_data[19];
  assign exp_in = in_data[18:13];
  assign mant   = in_data[12:0];
  assign lsb    = mant[4];
  assign guard  = mant[3];
  assign sticky = |mant[2:0];

  always_comb begin
    round_up = guard & (sticky | lsb);
    frac_sum = {1'b0, mant[12:4]} + {9'd0, round_up};
    if (frac_sum[9]) begin
      frac_r = 9'd0;
      exp_r  = {1'b0, exp_in} + 7'd1;
    end else begin
      frac_r = frac_sum[8:0];
      exp_r  = {1'b0, exp_in};
    end
    // Upstream overflow forces the same saturate/NaN handling as a rounding overflow.
    overflow = exp_r[6] | ((exp_r[5:0] == 6'h3F) & (frac_r == 9'h1FF)) | in_flags[2];

    res_data  = {sign, exp_r[5:0], frac_r};
    res_flags = in_flags | ((guard | sticky) ? FL_NX : 5'd0);
    if ((in_data == 20'hFFFFF) || in_flags[4]) begin
      res_data  = NAN_CODE;
      res_flags = in_flags | FL_INV;
    end else if (exp_in == 6'd0) begin
      res_data  = {sign, 15'd0};
      res_flags = in_flags | ((mant != 13'd0) ? (FL_UF | FL_NX) : 5'd0);
    end else if (overflow) begin
      res_data  = SATURATE ? {sign, 15'h7FFE} : NAN_CODE;
      res_flags = in_flags | FL_OF | FL_NX;
    end
  end

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [4:0]  out_flags_q, out_flags_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_data_q, skid_data_d;
  logic [4:0]  skid_flags_q, skid_flags_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        accept, emit, out_load;

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  assign accept   = in_valid & ~skid_valid_q;
  assign emit     = out_valid_q & out_ready;
  assign out_load = ~out_valid_q | emit;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_flags_d  = out_flags_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    fflags_d     = (fflags_clr ? 5'd0 : fflags_q) | (emit ? out_flags_q : 5'd0);
    if (out_load) begin
      // A held skid beat is older than anything on the input, so it goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_flags_d  = skid_flags_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = res_data;
        out_flags_d = res_flags;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = res_data;
      skid_flags_d = res_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'd0;
      out_flags_q  <= 5'd0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 16'd0;
      skid_flags_q <= 5'd0;
      fflags_q     <= 5'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
      fflags_q     <= fflags_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_dlfloat16_round_pack.sv
// Scoreboarded bench for dlfloat16_round_pack: directed rounding/special cases,
// backpressure through the skid register, sticky flags, and a random stream.
module tb_dlfloat16_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_emit   = 0;
  logic [20:0] exp_q[$];

  dlfloat16_round_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: round via remainder of mant/16 rather than guard/sticky bits.
  function automatic logic [20:0] model(input logic [19:0] d, input logic [4:0] f);
    logic s;
    int e, m, q, rem, v;
    logic [5:0] e6;
    logic [8:0] v9;
    s = d[19];
    e = int'(d[18:13]);
    m = int'(d[12:0]);
    if (d == 20'hFFFFF || f[4]) return {16'hFFFF, f | 5'b10000};
    if (e == 0) return {s, 15'd0, (m != 0) ? (f | 5'b01010) : f};
    q = m / 16;
    rem = m % 16;
    v = q;
    if (rem > 8 || (rem == 8 && q % 2 == 1)) v = q + 1;
    if (v == 512) begin
      v = 0;
      e = e + 1;
    end
    if (e > 63 || (e == 63 && v == 511) || f[2]) return {s, 15'h7FFE, f | 5'b01100};
    e6 = e[5:0];
    v9 = v[8:0];
    return {s, e6, v9, (rem != 0) ? (f | 5'b01000) : f};
  endfunction

  // driver tasks
  task automatic send(input logic [19:0] d, input logic [4:0] f, input logic [20:0] e);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_flags = f;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("send_accept", in_ready, 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [19:0] d, input logic [4:0] f);
    send(d, f, model(d, f));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drained", exp_q.size() == 0, 1);
  endtask

  // scoreboard: compare every output handshake against the oldest expectation
  always @(negedge clk) begin
    logic [20:0] e;
    if (rst_n && out_valid && out_ready) begin
      n_emit++;
      check_eq("out_has_expect", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_word", {out_data, out_flags}, e);
      end
    end
  end

  logic [19:0] dir_d[7] = '{20'h42018, 20'h42008, 20'h7FFF8, 20'h7DFFF,
                            20'hFFFFF, 20'h00000, 20'h00010};
  logic [4:0]  dir_f[7] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b10000, 5'b0, 5'b0};
  logic [20:0] dir_e[7] = '{{16'h4202, 5'b01000}, {16'h4200, 5'b01000}, {16'h7FFE, 5'b01100},
                            {16'h7E00, 5'b01000}, {16'hFFFF, 5'b10000}, {16'h0000, 5'b00000},
                            {16'h0000, 5'b01010}};

  initial begin
    int emit0;
    bit done;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_flags = '0;
    out_ready = 1'b1; fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_word", {out_data, out_flags}, 0);
    check_eq("rst_fflags", fflags, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // exact pass-through and one-cycle latency
    send(20'h42000, 5'b0, {16'h4200, 5'b0});
    check_eq("latency", out_valid, 1);
    idle();
    drain();

    // directed rounding / special cases, back-to-back
    for (int i = 0; i < 7; i++) send(dir_d[i], dir_f[i], dir_e[i]);
    idle();
    drain();

    // backpressure: 5 back-to-back beats, out_ready low for 3 cycles
    emit0 = n_emit;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_m({1'b0, 6'd20 + 6'(i), 13'(i * 37 + 5)}, 5'b0);
        idle();
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        check_eq("skid_full_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", n_emit - emit0, 5);

    // sticky flags
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    check_eq("fflags_cleared", fflags, 0);
    send(20'h42008, 5'b0, {16'h4200, 5'b01000});
    send(20'hFFFFF, 5'b10000, {16'hFFFF, 5'b10000});
    idle();
    drain();
    @(posedge clk);
    #1;
    check_eq("fflags_accum", fflags, 5'b11000);
    out_ready = 1'b0;
    send(20'h7FFF8, 5'b0, {16'h7FFE, 5'b01100});
    idle();
    check_eq("stall_valid", out_valid, 1);
    fflags_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    check_eq("fflags_clr_emit", fflags, 5'b01100);

    // reset in the middle of a stall with the skid full
    out_ready = 1'b0;
    send_m(20'h44123, 5'b0);
    send_m(20'hC6ABC, 5'b0);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_fflags", fflags, 0);
    check_eq("midrst_out_word", {out_data, out_flags}, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_no_ghost", out_valid, 0);

    // random stream with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_m(20'($urandom_range(0, 20'hFFFFF)),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b0);
          if ($urandom_range(0, 2) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    check_eq("queue_empty", exp_q.size() == 0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dlfloat16_round_pack.md
Name: dlfloat16_round_pack

Overview:
- Downstream stage of the DLfloat16 square-root unit. Consumes its 20-bit extended result {sign, exp[5:0], mant[12:0]} and its 5-bit exception flags.
- Rounds to nearest-even and packs to a 16-bit DLfloat16 word {sign, exp[5:0], frac[8:0]}, bias 31, no denormals.
- Registered, with a valid/ready handshake and a skid buffer.
- Keeps a sticky accumulated-flags register, the FPU status flags, readable by the core.

Parameters:
- SATURATE, 1, on overflow: 1 = output max finite of same sign (0x7FFE/0xFFFE); 0 = output NaN 0xFFFF.
- NAN_CODE, 16'hFFFF, canonical NaN encoding emitted for invalid results.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept; equals "skid register empty".
- in_data  in  20  extended result {sign, exp[5:0], mant[12:0]}; mant[12:4] fraction, mant[3] guard, mant[2:0] sticky bits.
- in_flags  in  5  upstream flags {invalid, inexact, overflow, underflow, div_by_zero}.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream can accept.
- out_data  out  16  packed DLfloat16 result.
- out_flags  out  5  per-result flags, upstream OR generated, same bit order as in_flags.
- fflags  out  5  sticky OR of out_flags over all completed output handshakes.
- fflags_clr  in  1  clears fflags.

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, out_data=0, out_flags=0, fflags=0, skid empty, in_ready=1 the cycle after.
- Accept on in_valid&&in_ready. Emit on out_valid&&out_ready.
- Latency: 1 cycle. Data accepted at edge N appears with out_valid=1 after edge N. Full throughput, one result per cycle, when out_ready=1.
- Skid buffer:
  - Accept when the output register is full and not draining: data goes to the skid register, and in_ready drops next cycle.
  - When the output drains, the skid moves to the output register. Skid has priority over new input; ordering is strictly preserved.
  - No data loss or duplication under any valid/ready pattern.
  - in_ready is a registered signal and must not depend combinationally on out_ready.
- Rounding, combinational before capture:
  - Definitions: lsb=mant[4], G=mant[3], S=|mant[2:0].
  - Round-up when G&&(S||lsb). Result frac = mant[12:4]+up.
  - Carry out of frac: frac=0, exp+1.
  - inexact generated if G||S.
- Special cases, in priority order:
  1. in_data==20'hFFFFF or in_flags[4]: out_data=NAN_CODE, invalid=1, no other generated flags.
  2. exp==0: out_data={sign,15'b0}; underflow+inexact generated if mant!=0 (flush to zero).
  3. Rounded exp would exceed 63, or the packed result equals 0x7FFF/0xFFFF: overflow+inexact generated. out_data per SATURATE.
  4. Otherwise out_data={sign,exp',frac'}.
- out_flags = in_flags | generated flags, with upstream overflow forcing the overflow handling of case 3.
- fflags:
  - Per edge: fflags_next = (fflags_clr ? 0 : fflags) | (emit ? out_flags : 0).
  - Clear and emit in the same cycle: only the emitted flags remain.
- Reset mid-transfer discards output and skid contents. No output handshake occurs in the reset cycle.
- out_data and out_flags hold stable while out_valid&&!out_ready.

Test Plan:
- Exact pass-through: in_data=20'h42000, flags 0 -> out_data=16'h4200 (4.0), out_flags=0, out_valid one cycle after accept.
- Round-up: 20'h42018 -> 16'h4202, out_flags=5'b01000. Tie-to-even: 20'h42008 -> 16'h4200, inexact set.
- Overflow: 20'h7FFF8 -> 16'h7FFE with SATURATE=1 (16'hFFFF with SATURATE=0), out_flags=5'b01100. Also 20'h7DFFF -> 16'h7E00 with only inexact.
- NaN/zero: 20'hFFFFF with in_flags=5'b10000 -> 16'hFFFF, flags 5'b10000. 20'h00000 -> 16'h0000, flags 0. 20'h00010 -> 16'h0000, flags 5'b01010.
- Backpressure: 5 back-to-back inputs, out_ready held 0 for 3 cycles then 1. Required: in_ready=0 while skid full, all 5 outputs delivered in order, no duplicates.
- fflags: emit an inexact result, then a NaN result -> fflags=5'b11000. Pulse fflags_clr together with an overflow emit -> fflags=5'b01100. Assert rst_n=0 mid-stall -> out_valid=0 and fflags=0 next cycle.
